timing_gen: RTL and testbench

TIMING_GEN -- requirements
Module: timing_gen

---
 rtl/timing_gen.sv | 141 ++++++++++++++
 tb/tb_timing_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/timing_gen.sv
// ----------------------------------------------------------------------------
// timing_gen - beat/phase timing sequencer
//
// A start pushbutton (qd) launches a sequence of beats. Each beat is made of
// three one-clock phases T1, T2, T3. At the edge that ends T3, the controller
// inputs decide the next beat:
//   stop         -> return to idle
//   W1 + short   -> repeat W1
//   W1           -> W2
//   W2 + long    -> W3
//   W2 / W3      -> W1
//
// Ports
//   clk       in   system clock, rising edge
//   clr       in   synchronous active-high reset
//   qd        in   asynchronous start pushbutton (level)
//   short     in   end instruction after W1 (sampled at end of T3 only)
//   long      in   insert W3 after W2      (sampled at end of T3 only)
//   stop      in   halt after current beat (sampled at end of T3 only)
//   t1..t3    out  one-hot phase, all 0 when idle
//   w1..w3    out  one-hot beat, all 0 when idle
//   running   out  1 while sequencing
//   beat_cnt  out  completed beats since reset, wraps 255 -> 0
// ----------------------------------------------------------------------------
module timing_gen (
    input  logic       clk,
    input  logic       clr,
    input  logic       qd,
    input  logic       short,
    input  logic       long,
    input  logic       stop,
    output logic       t1,
    output logic       t2,
    output logic       t3,
    output logic       w1,
    output logic       w2,
    output logic       w3,
    output logic       running,
    output logic [7:0] beat_cnt
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [2:0] Sel1 = 3'b001;
    localparam logic [2:0] Sel2 = 3'b010;
    localparam logic [2:0] Sel3 = 3'b100;

    // Start pushbutton synchroniser and rising-edge detector
    logic       sync1_q, sync2_q, delay_q;
    // fill_q[1] marks that sync2_q holds a genuine post-reset qd sample
    logic [1:0] fill_q;
    // Set once qd has been seen low after reset, so a button held through
    // reset cannot launch the sequencer.
    logic       armed_q;
    logic       start;

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            delay_q <= 1'b0;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            sync1_q <= qd;
            sync2_q <= sync1_q;
            delay_q <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            armed_q <= armed_q | (fill_q[1] & ~sync2_q);
        end
    end

    assign start = sync2_q & ~delay_q & armed_q;

    // Sequencer state
    state_e     state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic [2:0] beat_q,  beat_d;
    logic [7:0] cnt_q,   cnt_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            phase_q <= 3'b000;
            beat_q  <= 3'b000;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    phase_d = Sel1;
                    beat_d  = Sel1;
                end
            end
            StRun: begin
                if (phase_q[2]) begin
                    // End of beat: controller inputs are only honoured here
                    cnt_d   = cnt_q + 8'd1;
                    phase_d = Sel1;
                    if (stop) begin
                        state_d = StIdle;
                        phase_d = 3'b000;
                        beat_d  = 3'b000;
                    end else if (beat_q[0]) begin
                        beat_d = short ? Sel1 : Sel2;
                    end else if (beat_q[1]) begin
                        beat_d = long ? Sel3 : Sel1;
                    end else begin
                        beat_d = Sel1;
                    end
                end else begin
                    phase_d = {phase_q[1:0], 1'b0};
                end
            end
        endcase
    end

    // All outputs come straight from flops
    assign t1       = phase_q[0];
    assign t2       = phase_q[1];
    assign t3       = phase_q[2];
    assign w1       = beat_q[0];
    assign w2       = beat_q[1];
    assign w3       = beat_q[2];
    assign running  = (state_q == StRun);
    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_timing_gen - scoreboard bench for timing_gen
//
// The driver applies one set of inputs per clock (on the falling edge) and
// pushes the outputs a reference model predicts for after the next rising
// edge. A monitor pops one prediction per rising edge and compares.
// ----------------------------------------------------------------------------
module tb_timing_gen;

    logic       clk = 1'b0;
    logic       clr, qd, short, long, stop;
    logic       t1, t2, t3, w1, w2, w3, running;
    logic [7:0] beat_cnt;

    always #5 clk = ~clk;

    timing_gen dut (
        .clk      (clk),
        .clr      (clr),
        .qd       (qd),
        .short    (short),
        .long     (long),
        .stop     (stop),
        .t1       (t1),
        .t2       (t2),
        .t3       (t3),
        .w1       (w1),
        .w2       (w2),
        .w3       (w3),
        .running  (running),
        .beat_cnt (beat_cnt)
    );

    typedef struct {
        logic [14:0] vec;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_no   = 0;

    // Reference model: beat/phase numbers (0 = idle), plain integer counter,
    // and the list of qd levels sampled at each rising edge since reset.
    bit m_run   = 1'b0;
    int m_beat  = 0;
    int m_phase = 0;
    int m_cnt   = 0;
    bit hist[$];

    task automatic cyc(input bit c, input bit q, input bit s, input bit l, input bit p);
        int   m;
        bit   start_now;
        exp_t e;
        @(negedge clk);
        clr   = c;
        qd    = q;
        short = s;
        long  = l;
        stop  = p;
        cyc_no++;
        if (c) begin
            m_run   = 1'b0;
            m_beat  = 0;
            m_phase = 0;
            m_cnt   = 0;
            hist.delete();
        end else begin
            // A press is recognised two edges after qd is first sampled high,
            // provided the previous sample (taken after reset) was low.
            m = hist.size();
            start_now = (m >= 3) && hist[m-2] && !hist[m-3];
            if (m_run) begin
                if (m_phase == 3) begin
                    m_cnt   = (m_cnt + 1) % 256;
                    m_phase = 1;
                    if (p) begin
                        m_run   = 1'b0;
                        m_phase = 0;
                        m_beat  = 0;
                    end else if (m_beat == 1) begin
                        m_beat = s ? 1 : 2;
                    end else if (m_beat == 2) begin
                        m_beat = l ? 3 : 1;
                    end else begin
                        m_beat = 1;
                    end
                end else begin
                    m_phase = m_phase + 1;
                end
            end else if (start_now) begin
                m_run   = 1'b1;
                m_beat  = 1;
                m_phase = 1;
            end
            hist.push_back(q);
        end
        e.vec = {m_run,
                 (m_phase == 3), (m_phase == 2), (m_phase == 1),
                 (m_beat == 3), (m_beat == 2), (m_beat == 1),
                 8'(m_cnt)};
        e.cyc = cyc_no;
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t        e;
        logic [14:0] act;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {running, t3, t2, t1, w3, w2, w1, beat_cnt};
                checks++;
                if (act !== e.vec) begin
                    failures++;
                    $display("FAIL outputs cycle %0d: run/t321/w321/cnt act=%b_%b_%b_%0d exp=%b_%b_%b_%0d",
                             e.cyc, act[14], act[13:11], act[10:8], act[7:0],
                             e.vec[14], e.vec[13:11], e.vec[10:8], e.vec[7:0]);
                end
            end
        end
    end

    initial begin
        bit q_cur;
        clr   = 1'b1;
        qd    = 1'b0;
        short = 1'b0;
        long  = 1'b0;
        stop  = 1'b0;

        // Reset, then a clean press held for 10 clocks with no controls
        repeat (3) cyc(1, 0, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 0, 0);
        repeat (10) cyc(0, 1, 0, 0, 0);
        repeat (20) cyc(0, 0, 0, 0, 0);

        // Long run with random short/long: beat counter wraps past 255
        repeat (820) cyc(0, 0, ($urandom_range(3) == 0), ($urandom_range(2) == 0), 0);

        // stop together with short until the end of a beat
        repeat (3) cyc(0, 0, 1, 0, 1);
        repeat (4) cyc(0, 0, 0, 0, 0);

        // Restart, then reset mid-run with qd still high; must stay idle
        repeat (12) cyc(0, 1, 0, 1, 0);
        repeat (2) cyc(1, 1, 0, 0, 0);
        repeat (15) cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (12) cyc(0, 1, 0, 0, 0);

        // Qd held high right through a reset release
        repeat (2) cyc(1, 1, 0, 0, 0);
        repeat (10) cyc(0, 1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);
        repeat (8) cyc(0, 1, 0, 0, 0);

        // Random traffic on every input
        q_cur = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11) == 0) q_cur = ~q_cur;
            cyc(($urandom_range(299) == 0), q_cur,
                ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                ($urandom_range(19) == 0));
        end

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
